uart_tx_arbiter: RTL and testbench

//  Shares one uart_tx transmitter among N_REQ requesters with round-robin arbitration.
//  - Grants one requester and launches its byte with a 1-cycle DATA_VALID pulse.
//  - Holds P_DATA/PAR_EN/PAR_TYP stable for the whole frame and tracks Busy to completion.
//  - Sits between client blocks and the uart_tx DATA_VALID/P_DATA/PAR_EN/PAR_TYP/Busy pins.

---
 rtl/uart_tx_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx among N_REQ requesters, round-robin.
//
// Purpose
//   Picks one requester, launches its byte into uart_tx with a one-cycle
//   DATA_VALID pulse, holds the frame fields steady and follows Busy until
//   the frame ends (done) or Busy never rises (timeout_err).
//
// Ports
//   clk, reset          single clock, synchronous active-high reset
//   req                 per-requester request, held until done/err
//   req_data            byte i at [8*i+7:8*i]
//   req_par_en          per-requester parity enable
//   req_par_typ         per-requester parity type
//   gnt                 one-hot grant, launch to frame end
//   done                one-cycle pulse to the winner on frame end
//   timeout_err         one-cycle pulse when Busy never rose
//   DATA_VALID          launch pulse to uart_tx
//   P_DATA              byte to uart_tx
//   PAR_EN, PAR_TYP     parity controls to uart_tx
//   Busy                uart_tx busy flag
module uart_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_par_en,
    input  logic [N_REQ-1:0]   req_par_typ,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   done,
    output logic               timeout_err,
    output logic               DATA_VALID,
    output logic [7:0]         P_DATA,
    output logic               PAR_EN,
    output logic               PAR_TYP,
    input  logic               Busy
);

    localparam int PW = $clog2(N_REQ);
    localparam int TW = 8;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   rr_ptr_nx;
    logic [PW-1:0]   win;
    logic [PW-1:0]   win_nx;
    logic [TW-1:0]   tmo_cnt;
    logic [TW-1:0]   tmo_cnt_nx;
    logic [PW-1:0]   pick;
    logic            pick_vld;

    logic [N_REQ-1:0] gnt_nx;
    logic [N_REQ-1:0] done_nx;
    logic             tmo_err_nx;
    logic             dv_nx;
    logic [7:0]       pdata_nx;
    logic             par_en_nx;
    logic             par_typ_nx;

    // Modular add that also works when N_REQ is not a power of two.
    function automatic logic [PW-1:0] wrap_add(
        input logic [PW-1:0] a,
        input int            b
    );
        int s;
        s = int'(a) + b;
        if (s >= N_REQ) s = s - N_REQ;
        return PW'(s);
    endfunction

    // Round-robin scan: walk from the farthest offset down to rr_ptr so the
    // nearest set bit (starting at rr_ptr) is the last one written.
    always_comb begin
        pick     = rr_ptr;
        pick_vld = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[wrap_add(rr_ptr, k)]) begin
                pick     = wrap_add(rr_ptr, k);
                pick_vld = 1'b1;
            end
        end
    end

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            win         <= '0;
            tmo_cnt     <= '0;
            gnt         <= '0;
            done        <= '0;
            timeout_err <= 1'b0;
            DATA_VALID  <= 1'b0;
            P_DATA      <= 8'h00;
            PAR_EN      <= 1'b0;
            PAR_TYP     <= 1'b0;
        end else begin
            state       <= state_nx;
            rr_ptr      <= rr_ptr_nx;
            win         <= win_nx;
            tmo_cnt     <= tmo_cnt_nx;
            gnt         <= gnt_nx;
            done        <= done_nx;
            timeout_err <= tmo_err_nx;
            DATA_VALID  <= dv_nx;
            P_DATA      <= pdata_nx;
            PAR_EN      <= par_en_nx;
            PAR_TYP     <= par_typ_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (pick_vld && !Busy) state_nx = LAUNCH;
            end
            LAUNCH: begin
                state_nx = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (Busy)
                    state_nx = WAIT_DONE;
                else if (tmo_cnt == TW'(TIMEOUT - 1))
                    state_nx = IDLE;
            end
            WAIT_DONE: begin
                if (!Busy) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Output/datapath next values; the frame fields only move at launch
    // so uart_tx can sample them at any point in the frame.
    always_comb begin
        gnt_nx     = gnt;
        done_nx    = '0;
        tmo_err_nx = 1'b0;
        dv_nx      = 1'b0;
        pdata_nx   = P_DATA;
        par_en_nx  = PAR_EN;
        par_typ_nx = PAR_TYP;
        win_nx     = win;
        rr_ptr_nx  = rr_ptr;
        tmo_cnt_nx = tmo_cnt;
        case (state)
            IDLE: begin
                if (pick_vld && !Busy) begin
                    win_nx       = pick;
                    gnt_nx       = '0;
                    gnt_nx[pick] = 1'b1;
                    pdata_nx     = req_data[int'(pick)*8 +: 8];
                    par_en_nx    = req_par_en[pick];
                    par_typ_nx   = req_par_typ[pick];
                    dv_nx        = 1'b1;
                end
            end
            LAUNCH: begin
                tmo_cnt_nx = '0;
            end
            WAIT_BUSY: begin
                if (!Busy) begin
                    if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                        tmo_err_nx = 1'b1;
                        gnt_nx     = '0;
                        rr_ptr_nx  = wrap_add(win, 1);
                    end else begin
                        tmo_cnt_nx = tmo_cnt + 1'b1;
                    end
                end
            end
            WAIT_DONE: begin
                if (!Busy) begin
                    done_nx[win] = 1'b1;
                    gnt_nx       = '0;
                    rr_ptr_nx    = wrap_add(win, 1);
                end
            end
            default: begin
                gnt_nx = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized bench for uart_tx_arbiter with a
// transaction-level reference model and a uart_tx busy stub.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 15;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_par_en;
    logic [N-1:0]   req_par_typ;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic           timeout_err;
    logic           DATA_VALID;
    logic [7:0]     P_DATA;
    logic           PAR_EN;
    logic           PAR_TYP;
    logic           Busy;

    logic stub_busy = 1'b0;
    logic foreign_busy = 1'b0;
    assign Busy = stub_busy | foreign_busy;

    uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data),
        .req_par_en(req_par_en), .req_par_typ(req_par_typ),
        .gnt(gnt), .done(done), .timeout_err(timeout_err),
        .DATA_VALID(DATA_VALID), .P_DATA(P_DATA), .PAR_EN(PAR_EN),
        .PAR_TYP(PAR_TYP), .Busy(Busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit check_en = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    int   m_ptr = 0, m_win = 0, m_age = 0;
    bit   m_act = 0, m_seen = 0;
    logic [N-1:0] e_gnt = '0, e_done = '0;
    logic e_tmo = 0, e_dv = 0, e_pe = 0, e_pt = 0;
    logic [7:0] e_pd = 8'h00;

    always @(posedge clk) begin
        e_done = '0;
        e_tmo  = 1'b0;
        e_dv   = 1'b0;
        if (reset) begin
            e_gnt = '0; e_pd = 8'h00; e_pe = 0; e_pt = 0;
            m_ptr = 0; m_act = 0;
        end else if (!m_act) begin
            if (req != '0 && !Busy) begin
                m_win = -1;
                for (int k = 0; k < N; k++)
                    if (m_win < 0 && req[(m_ptr + k) % N]) m_win = (m_ptr + k) % N;
                e_gnt = '0;
                e_gnt[m_win] = 1'b1;
                e_pd = req_data[8*m_win +: 8];
                e_pe = req_par_en[m_win];
                e_pt = req_par_typ[m_win];
                e_dv = 1'b1;
                m_act = 1; m_age = 0; m_seen = 0;
            end
        end else if (m_age == 0) begin
            m_age = 1;
        end else if (!m_seen) begin
            if (Busy) m_seen = 1;
            else if (m_age == TO) begin
                e_tmo = 1'b1; e_gnt = '0; m_act = 0; m_ptr = (m_win + 1) % N;
            end else m_age++;
        end else if (!Busy) begin
            e_done = '0;
            e_done[m_win] = 1'b1;
            e_gnt = '0; m_act = 0; m_ptr = (m_win + 1) % N;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (check_en) begin
            total++;
            if ({gnt, done, timeout_err, DATA_VALID, P_DATA, PAR_EN, PAR_TYP} !==
                {e_gnt, e_done, e_tmo, e_dv, e_pd, e_pe, e_pt}) begin
                bad++;
                $display("FAIL cycle@%0t: got gnt=%b done=%b tmo=%b dv=%b pd=%h pe=%b pt=%b want gnt=%b done=%b tmo=%b dv=%b pd=%h pe=%b pt=%b",
                         $time, gnt, done, timeout_err, DATA_VALID, P_DATA, PAR_EN, PAR_TYP,
                         e_gnt, e_done, e_tmo, e_dv, e_pd, e_pe, e_pt);
            end
        end
    end

    // ---------------- uart_tx busy stub ----------------
    bit dead = 0, rnd_dead = 0, long_frame = 0;
    int s_dly = 0, s_len = 0;

    always @(negedge clk) begin
        if (DATA_VALID) begin
            stub_busy = 1'b0;
            if (dead || (rnd_dead && $urandom_range(0, 7) == 0)) begin
                s_dly = 0; s_len = 0;
            end else begin
                s_dly = $urandom_range(0, 3);
                s_len = long_frame ? 20 : $urandom_range(1, 8);
            end
        end else if (s_dly > 0) s_dly--;
        else if (s_len > 0) begin stub_busy = 1'b1; s_len--; end
        else stub_busy = 1'b0;
    end

    // ---------------- requester side ----------------
    bit [N-1:0] auto_req = '0;
    int gap[N];
    int gap_max = 0;
    bit scramble = 0;
    int gq[$];
    logic [7:0] bq[$];

    function automatic int idx_of(input logic [N-1:0] g);
        for (int i = 0; i < N; i++) if (g[i]) return i;
        return -1;
    endfunction

    task automatic tick();
        @(negedge clk);
        if (DATA_VALID) begin
            gq.push_back(idx_of(gnt));
            bq.push_back(P_DATA);
        end
        for (int i = 0; i < N; i++) begin
            if (req[i] && (done[i] || (timeout_err && m_win == i))) begin
                req[i] = 1'b0;
                gap[i] = $urandom_range(0, gap_max);
            end
            if (scramble) begin
                req_data[8*i +: 8] = 8'($urandom);
                req_par_en[i]  = 1'($urandom);
                req_par_typ[i] = 1'($urandom);
            end
            if (auto_req[i] && !req[i]) begin
                if (gap[i] == 0) req[i] = 1'b1;
                else gap[i]--;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req = '0;
        auto_req = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_dv(input string name);
        int n = 0;
        while (!DATA_VALID && n < 200) begin tick(); n++; end
        if (!DATA_VALID) begin
            total++; bad++;
            $display("FAIL %s: got no DATA_VALID want launch", name);
        end
    endtask

    task automatic drain();
        int n = 0;
        auto_req = '0;
        while ((req != '0 || m_act || Busy) && n < 2000) begin tick(); n++; end
        if (n >= 2000) begin
            total++; bad++;
            $display("FAIL drain: got busy system want idle");
        end
    endtask

    logic [7:0] bytes4 [N] = '{8'h3C, 8'h5A, 8'h96, 8'hE1};

    initial begin
        int n;
        reset = 1'b1; req = '0; req_data = '0; req_par_en = '0; req_par_typ = '0;
        for (int i = 0; i < N; i++) gap[i] = 0;
        tick();
        check_en = 1;
        tick();
        check("reset_gnt", int'(gnt), 0);
        check("reset_dv", int'(DATA_VALID), 0);
        check("reset_pdata", int'(P_DATA), 0);
        reset = 1'b0;

        // single request
        req_data[7:0] = 8'hA5; req_par_en[0] = 1'b1; req_par_typ[0] = 1'b0;
        req = 4'b0001;
        wait_dv("single_dv");
        check("single_pdata", int'(P_DATA), 8'hA5);
        check("single_paren", int'(PAR_EN), 1);
        check("single_partyp", int'(PAR_TYP), 0);
        check("single_gnt", int'(gnt), 1);
        n = 0;
        while (done == '0 && !timeout_err && n < 100) begin tick(); n++; end
        check("single_done", int'(done), 1);
        drain();

        // all four at once after reset
        do_reset();
        for (int i = 0; i < N; i++) req_data[8*i +: 8] = bytes4[i];
        gq.delete(); bq.delete();
        req = 4'b1111;
        drain();
        check("all4_count", gq.size(), 4);
        for (int i = 0; i < 4 && i < gq.size(); i++) begin
            check($sformatf("all4_gnt%0d", i), gq[i], i);
            check($sformatf("all4_byte%0d", i), int'(bq[i]), int'(bytes4[i]));
        end

        // fairness: req0 and req2 held
        gq.delete(); bq.delete();
        gap_max = 0;
        auto_req = 4'b0101;
        n = 0;
        while (gq.size() < 4 && n < 500) begin tick(); n++; end
        auto_req = '0;
        check("rr_count", (gq.size() >= 4) ? 1 : 0, 1);
        for (int i = 0; i < 4 && i < gq.size(); i++)
            check($sformatf("rr_gnt%0d", i), gq[i], (i % 2 == 0) ? 0 : 2);
        drain();

        // timeout: Busy never rises
        dead = 1;
        req[1] = 1'b1;
        wait_dv("tmo_dv");
        n = 0;
        while (!timeout_err && n < 40) begin tick(); n++; end
        check("tmo_latency", n, 16);
        check("tmo_gnt_clear", int'(gnt), 0);
        check("tmo_no_done", int'(done), 0);
        dead = 0;
        req = 4'b1111;
        wait_dv("tmo_next_dv");
        check("tmo_next_gnt", int'(gnt), 4'b0100);
        drain();

        // foreign frame on uart_tx
        foreign_busy = 1'b1;
        req[3] = 1'b1;
        n = 0;
        for (int i = 0; i < 6; i++) begin tick(); n += int'(DATA_VALID); end
        check("foreign_no_dv", n, 0);
        foreign_busy = 1'b0;
        tick();
        check("foreign_dv_lat", int'(DATA_VALID), 1);
        drain();

        // reset in the middle of WAIT_DONE
        long_frame = 1;
        req[2] = 1'b1;
        n = 0;
        while (!(m_act && m_seen) && n < 100) begin tick(); n++; end
        tick();
        tick();
        reset = 1'b1;
        req = 4'b1010;
        tick();
        check("midrst_gnt", int'(gnt), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_dv", int'(DATA_VALID), 0);
        check("midrst_pdata", int'(P_DATA), 0);
        reset = 1'b0;
        long_frame = 0;
        wait_dv("midrst_dv2");
        check("midrst_first_gnt", int'(gnt), 4'b0010);
        drain();

        // random traffic
        scramble = 1; rnd_dead = 1; gap_max = 4;
        auto_req = '1;
        for (int c = 0; c < 1500; c++) begin
            tick();
            if ($urandom_range(0, 9) == 0) auto_req = 4'($urandom);
        end
        rnd_dead = 0;
        drain();
        scramble = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
